// File: rtl/mem_addr_sel_seq_if.sv
// -----------------------------------------------------------------------------
// mem_addr_sel_seq_if
// Bundles the request/response signals of the memory-address selector.
//   selector  source index, sampled with start
//   data_in   flattened address sources, source k = data_in[k*WIDTH +: WIDTH]
//   size      access size (00 byte, 01 half, 1x word), sampled with start
//   start     request a new access
//   flush     synchronous abort back to idle
//   mem_addr  registered selected address
//   mem_req   memory request, high for LAT cycles per accepted access
//   done      one-cycle completion pulse
//   misalign  one-cycle alignment-reject pulse
//   busy      access in progress
// master: drives the request side; slave: the selector block itself.
// -----------------------------------------------------------------------------
interface mem_addr_sel_seq_if #(
  parameter int WIDTH   = 32,
  parameter int NUM_SRC = 5,
  parameter int SEL_W   = 3
);
  logic [SEL_W-1:0]         selector;
  logic [NUM_SRC*WIDTH-1:0] data_in;
  logic [1:0]               size;
  logic                     start;
  logic                     flush;
  logic [WIDTH-1:0]         mem_addr;
  logic                     mem_req;
  logic                     done;
  logic                     misalign;
  logic                     busy;

  modport master (
    output selector, data_in, size, start, flush,
    input  mem_addr, mem_req, done, misalign, busy
  );

  modport slave (
    input  selector, data_in, size, start, flush,
    output mem_addr, mem_req, done, misalign, busy
  );
endinterface

// File: rtl/mem_addr_sel_seq.sv
// -----------------------------------------------------------------------------
// mem_addr_sel_seq
// Registered memory-address source mux with a fixed-latency request handshake.
// One of NUM_SRC sources is captured into the address register on an accepted
// start; mem_req is then held for LAT cycles, followed by a one-cycle done.
//
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      mem_addr_sel_seq_if.slave (selector, data_in, size, start, flush
//            in; mem_addr, mem_req, done, misalign, busy out)
//
// Configuration macro:
//   ADDR_ALIGN_CHK_EN  when defined, misaligned half/word accesses are rejected
//                      with a misalign pulse; when undefined, size is ignored
//                      and every start in idle proceeds to the request phase.
// -----------------------------------------------------------------------------
module mem_addr_sel_seq #(
  parameter int WIDTH   = 32,
  parameter int NUM_SRC = 5,
  parameter int SEL_W   = 3,
  parameter int LAT     = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  mem_addr_sel_seq_if.slave  bus
);

  localparam int CNT_W = $clog2(LAT + 1);
  localparam int SW1   = SEL_W + 1;

  localparam logic [SW1-1:0]   NUM_SRC_EXT = SW1'(NUM_SRC);
  localparam logic [SEL_W-1:0] LAST_SRC    = SEL_W'(NUM_SRC - 1);
  localparam logic [CNT_W-1:0] CNT_INIT    = CNT_W'(LAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

`ifdef ADDR_ALIGN_CHK_EN
  // Byte is always aligned; half needs bit 0 clear; word (and 11) needs [1:0] clear.
  function automatic logic addr_aligned(input logic [1:0] lsb, input logic [1:0] sz);
    logic ok;
    case (sz)
      2'b00:   ok = 1'b1;
      2'b01:   ok = ~lsb[0];
      default: ok = (lsb == 2'b00);
    endcase
    return ok;
  endfunction
`endif

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] mem_addr_q;
  logic             mem_req_q;
  logic             done_q;
  logic             misalign_q;
  logic             busy_q;

  logic [SEL_W-1:0] sel_idx_s;
  logic [WIDTH-1:0] src_s;
  logic             aligned_s;

  // Out-of-range selector values all fall onto the last source (legacy priority).
  always_comb begin
    sel_idx_s = LAST_SRC;
    if ({1'b0, bus.selector} < NUM_SRC_EXT) begin
      sel_idx_s = bus.selector;
    end else begin
      sel_idx_s = LAST_SRC;
    end
  end

  // Pick the selected source word out of the flattened input bus.
  always_comb begin
    src_s = bus.data_in[int'(sel_idx_s)*WIDTH +: WIDTH];
  end

  // Alignment verdict for the candidate address.
  always_comb begin
`ifdef ADDR_ALIGN_CHK_EN
    aligned_s = addr_aligned(src_s[1:0], bus.size);
`else
    aligned_s = 1'b1;
`endif
  end

  // Handshake FSM; all outputs are registered alongside the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      mem_addr_q <= '0;
      mem_req_q  <= 1'b0;
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      // Pulses default low; they are only raised on the transition that owns them.
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.flush) begin
            // flush wins over a simultaneous start: nothing is captured.
            state_q   <= ST_IDLE;
            mem_req_q <= 1'b0;
            busy_q    <= 1'b0;
          end else if (bus.start) begin
            // Capture even on reject so the bad address is visible to the handler.
            mem_addr_q <= src_s;
            if (aligned_s) begin
              state_q   <= ST_BUSY;
              cnt_q     <= CNT_INIT;
              mem_req_q <= 1'b1;
              busy_q    <= 1'b1;
            end else begin
              state_q    <= ST_IDLE;
              misalign_q <= 1'b1;
              mem_req_q  <= 1'b0;
              busy_q     <= 1'b0;
            end
          end else begin
            state_q   <= ST_IDLE;
            mem_req_q <= 1'b0;
            busy_q    <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (bus.flush) begin
            state_q   <= ST_IDLE;
            mem_req_q <= 1'b0;
            busy_q    <= 1'b0;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            state_q   <= ST_DONE;
            mem_req_q <= 1'b0;
            done_q    <= 1'b1;
          end
        end
        ST_DONE: begin
          // Leaves unconditionally; a flush here has the same effect.
          state_q   <= ST_IDLE;
          mem_req_q <= 1'b0;
          busy_q    <= 1'b0;
        end
        default: begin
          state_q   <= ST_IDLE;
          cnt_q     <= '0;
          mem_req_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_req  = mem_req_q;
  assign bus.done     = done_q;
  assign bus.misalign = misalign_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_mem_addr_sel_seq.sv
// -----------------------------------------------------------------------------
// tb_mem_addr_sel_seq
// Drives a LAT=3 and a LAT=1 instance with identical stimulus. A transaction-
// level model (remaining-cycles count per access) predicts every output each
// cycle; hand sequences add fixed expectations for the documented corner cases.
// -----------------------------------------------------------------------------
module tb_mem_addr_sel_seq;

  localparam int W  = 32;
  localparam int NS = 5;
  localparam int SW = 3;

  logic clk;
  logic reset_n;

  logic [SW-1:0]   sel;
  logic [NS*W-1:0] din;
  logic [1:0]      sz;
  logic            st;
  logic            fl;

  mem_addr_sel_seq_if #(.WIDTH(W), .NUM_SRC(NS), .SEL_W(SW)) if3 ();
  mem_addr_sel_seq_if #(.WIDTH(W), .NUM_SRC(NS), .SEL_W(SW)) if1 ();

  assign if3.selector = sel;
  assign if3.data_in  = din;
  assign if3.size     = sz;
  assign if3.start    = st;
  assign if3.flush    = fl;
  assign if1.selector = sel;
  assign if1.data_in  = din;
  assign if1.size     = sz;
  assign if1.start    = st;
  assign if1.flush    = fl;

  mem_addr_sel_seq #(.WIDTH(W), .NUM_SRC(NS), .SEL_W(SW), .LAT(3)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .bus(if3)
  );
  mem_addr_sel_seq #(.WIDTH(W), .NUM_SRC(NS), .SEL_W(SW), .LAT(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .bus(if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  // Reference model: rem = cycles left in the current access (LAT request
  // cycles followed by one done cycle); 0 means idle.
  int          lat_m [2];
  int          rem_m [2];
  logic [31:0] addr_m[2];
  logic        mis_m [2];

  logic [31:0] act_addr[2];
  logic        act_req [2];
  logic        act_done[2];
  logic        act_mis [2];
  logic        act_busy[2];

  assign act_addr[0] = if3.mem_addr;
  assign act_req[0]  = if3.mem_req;
  assign act_done[0] = if3.done;
  assign act_mis[0]  = if3.misalign;
  assign act_busy[0] = if3.busy;
  assign act_addr[1] = if1.mem_addr;
  assign act_req[1]  = if1.mem_req;
  assign act_done[1] = if1.done;
  assign act_mis[1]  = if1.misalign;
  assign act_busy[1] = if1.busy;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic ref_aligned(input logic [31:0] a, input logic [1:0] s);
`ifdef ADDR_ALIGN_CHK_EN
    if (s == 2'b00) return 1'b1;
    if (s == 2'b01) return (a % 2) == 0;
    return (a % 4) == 0;
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      rem_m[d]  = 0;
      addr_m[d] = 32'h0;
      mis_m[d]  = 1'b0;
    end
  endtask

  task automatic model_step(input int d);
    int          idx;
    logic [31:0] a;
    mis_m[d] = 1'b0;
    if (fl) begin
      rem_m[d] = 0;
    end else if (rem_m[d] > 0) begin
      rem_m[d] = rem_m[d] - 1;
    end else if (st) begin
      idx = (int'(sel) >= NS) ? NS - 1 : int'(sel);
      a   = din[idx*W +: W];
      addr_m[d] = a;
      if (ref_aligned(a, sz)) rem_m[d] = lat_m[d] + 1;
      else mis_m[d] = 1'b1;
    end
  endtask

  task automatic compare_all();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("lat%0d mem_addr", lat_m[d]), act_addr[d], addr_m[d]);
      chk($sformatf("lat%0d mem_req", lat_m[d]), {31'd0, act_req[d]}, {31'd0, rem_m[d] > 1});
      chk($sformatf("lat%0d done", lat_m[d]), {31'd0, act_done[d]}, {31'd0, rem_m[d] == 1});
      chk($sformatf("lat%0d misalign", lat_m[d]), {31'd0, act_mis[d]}, {31'd0, mis_m[d]});
      chk($sformatf("lat%0d busy", lat_m[d]), {31'd0, act_busy[d]}, {31'd0, rem_m[d] > 0});
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    compare_all();
  endtask

  task automatic idle_cycles(input int n);
    st = 1'b0;
    fl = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic load_sweep_data();
    for (int k = 0; k < NS; k++) din[k*W +: W] = 32'(k) * 32'h100;
  endtask

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] exp_addr;
  } sweep_t;

  sweep_t tbl[8];

  initial begin
    n_vec = 0;
    n_err = 0;
    lat_m[0] = 3;
    lat_m[1] = 1;
    model_reset();
    reset_n = 1'b0;
    sel = 3'd0; din = '0; sz = 2'b10; st = 1'b0; fl = 1'b0;

    tbl[0] = '{3'd0, 32'h000};
    tbl[1] = '{3'd1, 32'h100};
    tbl[2] = '{3'd2, 32'h200};
    tbl[3] = '{3'd3, 32'h300};
    tbl[4] = '{3'd4, 32'h400};
    tbl[5] = '{3'd5, 32'h400};
    tbl[6] = '{3'd6, 32'h400};
    tbl[7] = '{3'd7, 32'h400};

    #22;
    reset_n = 1'b1;
    #1;
    chk("reset mem_addr", if3.mem_addr, 32'h0);
    chk("reset busy", {31'd0, if3.busy}, 32'd0);
    chk("reset mem_req", {31'd0, if3.mem_req}, 32'd0);
    compare_all();

    // Select sweep: each entry is a full word access.
    load_sweep_data();
    sz = 2'b10;
    for (int i = 0; i < 8; i++) begin
      sel = tbl[i].sel;
      st  = 1'b1;
      cycle();
      chk($sformatf("sweep sel=%0d addr", tbl[i].sel), if3.mem_addr, tbl[i].exp_addr);
      chk($sformatf("sweep sel=%0d lat1 addr", tbl[i].sel), if1.mem_addr, tbl[i].exp_addr);
      idle_cycles(4);
    end

    // Timing: start in T; retry in T+2 must be ignored; start in T+5 accepted.
    sel = 3'd1; st = 1'b1;
    cycle();                                            // T+1
    chk("t+1 lat3 req", {31'd0, if3.mem_req}, 32'd1);
    chk("t+1 lat1 req", {31'd0, if1.mem_req}, 32'd1);
    st = 1'b0;
    cycle();                                            // T+2
    chk("t+2 lat3 req", {31'd0, if3.mem_req}, 32'd1);
    chk("t+2 lat1 done", {31'd0, if1.done}, 32'd1);
    sel = 3'd3; st = 1'b1;
    cycle();                                            // T+3
    chk("t+3 lat3 req", {31'd0, if3.mem_req}, 32'd1);
    chk("t+3 lat3 addr held", if3.mem_addr, 32'h100);
    chk("t+3 lat1 idle", {31'd0, if1.busy}, 32'd0);
    st = 1'b0;
    cycle();                                            // T+4
    chk("t+4 lat3 done", {31'd0, if3.done}, 32'd1);
    chk("t+4 lat3 req", {31'd0, if3.mem_req}, 32'd0);
    cycle();                                            // T+5
    chk("t+5 lat3 done", {31'd0, if3.done}, 32'd0);
    chk("t+5 lat3 busy", {31'd0, if3.busy}, 32'd0);
    sel = 3'd2; st = 1'b1;
    cycle();                                            // T+6
    chk("t+6 lat3 accepted", {31'd0, if3.busy}, 32'd1);
    chk("t+6 lat3 addr", if3.mem_addr, 32'h200);
    idle_cycles(5);

`ifdef ADDR_ALIGN_CHK_EN
    // Misaligned word at 0x1002 is rejected, then the same address as a byte goes through.
    din[0 +: W] = 32'h1002; sel = 3'd0; sz = 2'b10; st = 1'b1;
    cycle();
    chk("misalign pulse", {31'd0, if3.misalign}, 32'd1);
    chk("misalign addr", if3.mem_addr, 32'h1002);
    chk("misalign no req", {31'd0, if3.mem_req}, 32'd0);
    st = 1'b0;
    cycle();
    chk("misalign one cycle", {31'd0, if3.misalign}, 32'd0);
    chk("misalign still no req", {31'd0, if3.mem_req}, 32'd0);
    sz = 2'b00; st = 1'b1;
    cycle();
    chk("byte access req", {31'd0, if3.mem_req}, 32'd1);
    idle_cycles(5);
`else
    // Without the check, an odd word address is a normal access.
    din[0 +: W] = 32'h1003; sel = 3'd0; sz = 2'b10; st = 1'b1;
    cycle();
    chk("nochk req", {31'd0, if3.mem_req}, 32'd1);
    chk("nochk misalign", {31'd0, if3.misalign}, 32'd0);
    chk("nochk addr", if3.mem_addr, 32'h1003);
    idle_cycles(5);
`endif

    // Flush in the second BUSY cycle of the LAT=3 access.
    load_sweep_data();
    sz = 2'b10; sel = 3'd4; st = 1'b1;
    cycle();
    st = 1'b0;
    cycle();
    fl = 1'b1;
    cycle();
    chk("flush req", {31'd0, if3.mem_req}, 32'd0);
    chk("flush busy", {31'd0, if3.busy}, 32'd0);
    chk("flush addr held", if3.mem_addr, 32'h400);
    fl = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("flush no done", {31'd0, if3.done}, 32'd0);
    end

    // Asynchronous reset in the middle of BUSY.
    sel = 3'd2; st = 1'b1;
    cycle();
    st = 1'b0;
    cycle();
    #3;
    reset_n = 1'b0;
    #1;
    chk("async rst req", {31'd0, if3.mem_req}, 32'd0);
    chk("async rst busy", {31'd0, if3.busy}, 32'd0);
    chk("async rst done", {31'd0, if3.done}, 32'd0);
    chk("async rst addr", if3.mem_addr, 32'h0);
    model_reset();
    #2;
    reset_n = 1'b1;
    idle_cycles(1);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < NS; k++) din[k*W +: W] = $urandom;
      sel = 3'($urandom_range(0, 7));
      sz  = 2'($urandom_range(0, 3));
      st  = ($urandom_range(0, 2) != 0);
      fl  = ($urandom_range(0, 11) == 0);
      cycle();
    end
    idle_cycles(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
